// File: rtl/seq_tx_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
package seq_tx_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int PAT_W_DEF = 4;
  localparam int REP_W_DEF = 4;
  localparam int GAP_W_DEF = 3;

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern word over valid/ready and
// streams it MSB-first, repeated rep_cnt times with gap_len idle cycles
// between repetitions.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_e           state_reg,     state_next;
  logic [PAT_W-1:0] shift_reg,     shift_next;
  logic [PAT_W-1:0] pat_reg,       pat_next;
  logic [IDX_W-1:0] idx_reg,       idx_next;
  logic [REP_W-1:0] reps_left_reg, reps_left_next;
  logic [GAP_W-1:0] gap_reg,       gap_next;
  logic [GAP_W-1:0] gap_cnt_reg,   gap_cnt_next;
  logic             done_reg,      done_next;

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      pat_reg       <= '0;
      idx_reg       <= '0;
      reps_left_reg <= '0;
      gap_reg       <= '0;
      gap_cnt_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      pat_reg       <= pat_next;
      idx_reg       <= idx_next;
      reps_left_reg <= reps_left_next;
      gap_reg       <= gap_next;
      gap_cnt_reg   <= gap_cnt_next;
      done_reg      <= done_next;
    end
  end

  // Next-state logic: capture in IDLE, shift out in SHIFT, count idle in GAP
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    pat_next       = pat_reg;
    idx_next       = idx_reg;
    reps_left_next = reps_left_reg;
    gap_next       = gap_reg;
    gap_cnt_next   = gap_cnt_reg;
    done_next      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pat_valid) begin
          shift_next     = pat_data;
          pat_next       = pat_data;
          // A zero count still sends the pattern once
          reps_left_next = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
          gap_next       = gap_len;
          idx_next       = IDX_LAST;
          state_next     = SHIFT;
        end
      end

      SHIFT: begin
        shift_next = shift_reg << 1;
        idx_next   = idx_reg - IDX_W'(1);
        if (idx_reg == '0) begin
          if (reps_left_reg == REP_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (gap_reg == '0) begin
            // Reload on the same edge so the stream has no bubble
            shift_next     = pat_reg;
            idx_next       = IDX_LAST;
            reps_left_next = reps_left_reg - REP_W'(1);
          end else begin
            gap_cnt_next = gap_reg;
            state_next   = GAP;
          end
        end
      end

      GAP: begin
        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        if (gap_cnt_reg == GAP_W'(1)) begin
          shift_next     = pat_reg;
          idx_next       = IDX_LAST;
          reps_left_next = reps_left_reg - REP_W'(1);
          state_next     = SHIFT;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state_reg == SHIFT);
  assign out_bit   = out_valid & shift_reg[PAT_W-1];
  assign busy      = (state_reg != IDLE);
  assign pat_ready = (state_reg == IDLE);
  assign done      = done_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a per-cycle scoreboard of expected
// stream entries is filled at request time and drained by a monitor.
module tb_seq_pattern_tx;
  import seq_tx_pkg::*;

  localparam int PW = 4;
  localparam int RW = 4;
  localparam int GW = 3;

  logic          clk;
  logic          rst_n;
  logic          pat_valid;
  logic          pat_ready;
  logic [PW-1:0] pat_data;
  logic [RW-1:0] rep_cnt;
  logic [GW-1:0] gap_len;
  logic          out_bit;
  logic          out_valid;
  logic          busy;
  logic          done;

  seq_pattern_tx #(.PAT_W(PW), .REP_W(RW), .GAP_W(GW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_data  (pat_data),
    .rep_cnt   (rep_cnt),
    .gap_len   (gap_len),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic v;
    logic b;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  int   cov[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Push the expected busy-cycle stream (bits and gap slots) for one request
  task automatic push_pattern(input logic [PW-1:0] pat, input logic [RW-1:0] rep,
                              input logic [GW-1:0] gap);
    int reps;
    exp_t e;
    reps = (rep == 0) ? 1 : int'(rep);
    for (int r = 0; r < reps; r++) begin
      for (int i = PW - 1; i >= 0; i--) begin
        e.v = 1'b1;
        e.b = pat[i];
        exp_q.push_back(e);
      end
      if (r < reps - 1) begin
        for (int g = 0; g < int'(gap); g++) begin
          e.v = 1'b0;
          e.b = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Monitor: drain the scoreboard on every busy cycle, count done pulses
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (busy || out_valid)) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_valid", {31'd0, out_valid}, {31'd0, e.v});
        check("out_bit", {31'd0, out_bit}, {31'd0, e.b});
      end
    end
    if (!out_valid) check("out_bit_idle_zero", {31'd0, out_bit}, 32'd0);
    if (done) done_cnt++;
    cov[int'(dut.state_reg)]++;
  end

  // One full request: drive, wait for completion, check timing and done
  task automatic run_req(input string tag, input logic [PW-1:0] pat,
                         input logic [RW-1:0] rep, input logic [GW-1:0] gap);
    int cyc;
    int d0;
    int reps;
    int exp_busy;
    cyc      = 0;
    d0       = done_cnt;
    reps     = (rep == 0) ? 1 : int'(rep);
    exp_busy = PW * reps + int'(gap) * (reps - 1);
    @(negedge clk);
    check({tag, "_ready_before"}, {31'd0, pat_ready}, 32'd1);
    pat_data  = pat;
    rep_cnt   = rep;
    gap_len   = gap;
    pat_valid = 1'b1;
    push_pattern(pat, rep, gap);
    @(posedge clk);
    #1 pat_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else break;
    end
    check({tag, "_busy_ends"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
    check({tag, "_ready_after"}, {31'd0, pat_ready}, 32'd1);
    check({tag, "_busy_cycles"}, cyc, exp_busy);
    @(negedge clk);
    check({tag, "_done_clears"}, {31'd0, done}, 32'd0);
    check({tag, "_done_count"}, done_cnt - d0, 32'd1);
    check({tag, "_sb_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int d0;
    int cyc;
    rst_n     = 1'b0;
    pat_valid = 1'b0;
    pat_data  = '0;
    rep_cnt   = '0;
    gap_len   = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_bit", {31'd0, out_bit}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pat_ready", {31'd0, pat_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single transmission, then repeated back-to-back, then with gaps
    run_req("single", 4'b1011, 4'd1, 3'd0);
    run_req("rep3_nogap", 4'b1011, 4'd3, 3'd0);
    run_req("rep2_gap2", 4'b1001, 4'd2, 3'd2);
    run_req("rep3_gap1", 4'b1110, 4'd3, 3'd1);

    // rep_cnt=0 sends once; a held request is accepted only in the done cycle
    d0 = done_cnt;
    @(negedge clk);
    pat_data  = 4'b0110;
    rep_cnt   = 4'd0;
    gap_len   = 3'd3;
    pat_valid = 1'b1;
    push_pattern(4'b0110, 4'd0, 3'd3);
    @(posedge clk);
    #1;
    pat_data = 4'b1100;
    rep_cnt  = 4'd1;
    gap_len  = 3'd0;
    push_pattern(4'b1100, 4'd1, 3'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("held_ready_low", {31'd0, pat_ready}, 32'd0);
      check("held_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("held_done_cycle_done", {31'd0, done}, 32'd1);
    check("held_done_cycle_ready", {31'd0, pat_ready}, 32'd1);
    @(posedge clk);
    #1 pat_valid = 1'b0;
    @(negedge clk);
    check("held_next_starts", {31'd0, out_valid}, 32'd1);
    cyc = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else break;
    end
    check("held_second_busy", cyc, 32'd4);
    check("held_second_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("held_done_count", done_cnt - d0, 32'd2);
    check("held_sb_drained", exp_q.size(), 32'd0);

    // Reset during bit 2 of repetition 2 of 3
    d0 = done_cnt;
    @(negedge clk);
    pat_data  = 4'b1011;
    rep_cnt   = 4'd3;
    gap_len   = 3'd0;
    pat_valid = 1'b1;
    push_pattern(4'b1011, 4'd1, 3'd0);
    exp_q.push_back('{v: 1'b1, b: 1'b1});
    @(posedge clk);
    #1 pat_valid = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_bit", {31'd0, out_bit}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ready", {31'd0, pat_ready}, 32'd1);
    repeat (2) @(negedge clk);
    check("midrst_no_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_done_count", done_cnt - d0, 32'd0);
    check("midrst_sb_drained", exp_q.size(), 32'd0);
    run_req("after_rst", 4'b1000, 4'd2, 3'd1);

    check("cov_idle", {31'd0, cov[int'(IDLE)] > 0}, 32'd1);
    check("cov_shift", {31'd0, cov[int'(SHIFT)] > 0}, 32'd1);
    check("cov_gap", {31'd0, cov[int'(GAP)] > 0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so a stuck design still terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: accepts a PAT_W-bit pattern word over a valid/ready handshake and emits it MSB-first as a one-bit-per-clock stream.
- Repeats the pattern a programmable number of times, with a programmable idle gap between repetitions.
- Acts as the stimulus/transmit end of the team's serial bit-pattern links; its out_bit feeds serial pattern detectors, one bit per clock.

Parameters:
- PAT_W, 4: pattern width in bits (>=2).
- REP_W, 4: width of repetition-count field.
- GAP_W, 3: width of inter-repetition gap-length field.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- pat_valid, input, 1: request valid; pat_data/rep_cnt/gap_len are stable while high.
- pat_ready, output, 1: block can accept a request.
- pat_data, input, PAT_W: pattern, transmitted MSB first.
- rep_cnt, input, REP_W: number of transmissions; 0 is treated as 1.
- gap_len, input, GAP_W: idle cycles between repetitions; 0 means back-to-back.
- out_bit, output, 1: serial data; forced 0 whenever out_valid=0.
- out_valid, output, 1: out_bit carries a pattern bit this cycle.
- busy, output, 1: transfer in progress (state != IDLE).
- done, output, 1: one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset (async assert, sync release): state=IDLE; shift register, rep and gap counters cleared; out_bit=0, out_valid=0, busy=0, done=0, pat_ready=1.
- FSM states: IDLE, SHIFT, GAP. Registered state, shift register (PAT_W), saved pattern (PAT_W), bit index, reps_left (REP_W), saved gap_len, gap_cnt (GAP_W), done flop.
- IDLE:
  - pat_ready=1; out_valid=0.
  - On pat_valid&&pat_ready at edge k, capture pat_data into the shift register and the saved pattern.
  - Set reps_left = (rep_cnt==0 ? 1 : rep_cnt), save gap_len, set bit index = PAT_W-1, go to SHIFT.
  - First bit appears in cycle k+1 (1-cycle latency).
- SHIFT:
  - out_valid=1; out_bit = shift register MSB. Each edge shifts left and decrements the index.
  - On the edge leaving the last bit (index 0):
    - reps_left==1: go to IDLE and set done=1 for exactly one cycle (the first IDLE cycle).
    - Else, saved gap==0: reload the shift register from the saved pattern, decrement reps_left, stay in SHIFT. Gives a continuous stream with no bubble.
    - Else: gap_cnt = saved gap, go to GAP.
- GAP:
  - out_valid=0, out_bit=0. gap_cnt decrements each edge.
  - When gap_cnt==1: reload the pattern, decrement reps_left, go to SHIFT. Gap length is exactly gap_len cycles.
- pat_ready=0 in SHIFT and GAP. pat_valid while busy is ignored, with no capture; the sender holds the request.
- Back-to-back requests: in the done cycle pat_ready=1, so a new request is accepted there. Minimum spacing is one idle cycle between the last bit of one request and the first bit of the next.
- done and handshake in the same cycle are legal; done still pulses exactly once.
- Inputs are sampled only at acceptance; changes to pat_data/rep_cnt/gap_len during busy have no effect.
- rst_n asserted mid-transfer: immediate return to reset values, no done pulse, and the partially sent pattern is abandoned.
- Total out_valid cycles per request = PAT_W * max(rep_cnt,1). Total busy cycles = that + gap_len * (max(rep_cnt,1)-1).

Decomposition:
- Package seq_tx_pkg: state enum typedef (IDLE, SHIFT, GAP, logic [1:0]); default width constants PAT_W_DEF=4, REP_W_DEF=4, GAP_W_DEF=3.
- No sub-module: the FSM, shift register and two down-counters fit in one module. The testbench reuses the package enum for state-coverage bins.

Test Plan:
- Reset, then pat_data=4'b1011, rep_cnt=1, gap_len=0 -> out_bit 1,0,1,1 with out_valid high for 4 cycles starting the cycle after acceptance; done high in cycle 5; pat_ready back to 1.
- pat_data=4'b1011, rep_cnt=3, gap_len=0 -> 12 contiguous valid bits 101110111011, no bubbles; exactly one done pulse after bit 12.
- pat_data=4'b1001, rep_cnt=2, gap_len=2 -> valid 1001, two cycles out_valid=0/out_bit=0, valid 1001, done; busy high for 10 cycles.
- rep_cnt=0 with pattern 4'b0110 -> transmitted once (0110), done once; pat_valid held high during busy with different data -> ignored, accepted only in the done cycle, next pattern starts the following cycle.
- rst_n pulsed low during the second bit of rep 2 of 3 -> outputs immediately 0, busy=0, pat_ready=1, no done; a fresh request afterward transmits correctly from its MSB.
